// File: rtl/lif_sched_pkg.sv
// Shared types, default synaptic weights and width helpers for the LIF spike scheduler.
package lif_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int DEF_W0 = 5;
    localparam int DEF_W1 = 4;
    localparam int DEF_W2 = 3;
    localparam int DEF_W3 = 0;

    // Two guard bits above the current width so one more weight never wraps before the clamp.
    function automatic int acc_width(input int w_width);
        return w_width + 2;
    endfunction

    function automatic int def_weight(input int idx);
        case (idx)
            0:       return DEF_W0;
            1:       return DEF_W1;
            2:       return DEF_W2;
            default: return DEF_W3;
        endcase
    endfunction

endpackage

// File: rtl/lif_sched_if.sv
// Spike, weight-config and current bus between the scheduler (slave) and its environment (master).
interface lif_sched_if #(
    parameter int N_SRC   = 3,
    parameter int W_WIDTH = 4
);
    logic [N_SRC-1:0]   spike_in;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [W_WIDTH-1:0] cfg_wdata;
    logic [N_SRC-1:0]   grant;
    logic [W_WIDTH-1:0] current_out;
    logic               current_valid;
    logic               busy;
    logic               drop_sticky;

    modport master (
        output spike_in, cfg_we, cfg_addr, cfg_wdata,
        input  grant, current_out, current_valid, busy, drop_sticky
    );

    modport slave (
        input  spike_in, cfg_we, cfg_addr, cfg_wdata,
        output grant, current_out, current_valid, busy, drop_sticky
    );
endinterface

// File: rtl/lif_rr_arbiter.sv
// Round-robin pick of one pending source starting at rr_ptr; returns the one-hot grant and next pointer.
module lif_rr_arbiter #(
    parameter int N_SRC = 3
) (
    input  logic             en,
    input  logic [N_SRC-1:0] pending,
    input  logic [1:0]       rr_ptr,
    output logic [N_SRC-1:0] grant,
    output logic [1:0]       grant_idx,
    output logic             grant_vld,
    output logic [1:0]       rr_ptr_nxt
);

    logic [1:0] idx;

    // NOTE: every output gets a default before any branch so no path leaves a latch behind.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_vld  = 1'b0;
        rr_ptr_nxt = rr_ptr;
        idx        = '0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = 2'((int'(rr_ptr) + off) % N_SRC);
            if (en && !grant_vld && pending[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
                rr_ptr_nxt = 2'((int'(idx) + 1) % N_SRC);
            end
        end
    end

endmodule

// File: rtl/lif_spike_scheduler.sv
// Time-multiplexed synaptic integrator: pending spikes are granted one per cycle into a saturating
// window accumulator. Define LIF_SCHED_CFG_EN for writable weights; otherwise weights are constants.
module lif_spike_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_SRC   = 3,
    parameter int W_WIDTH = 4,
    parameter int WINDOW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    lif_sched_if.slave  bus
);

    localparam int                 ACC_W    = acc_width(W_WIDTH);
    localparam logic [ACC_W-1:0]   ACC_MAX  = ACC_W'((1 << W_WIDTH) - 1);
    localparam logic [3:0]         WIN_LAST = 4'(WINDOW - 1);

    state_e             state_q, state_d;
    logic [3:0]         win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [1:0]         rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
    logic [N_SRC-1:0]   pending_q, pending_d, grant;
    logic [W_WIDTH-1:0] current_out_q, current_out_d;
    logic               current_valid_q, current_valid_d;
    logic               drop_sticky_q, drop_sticky_d;
    logic [1:0]         grant_idx;
    logic               grant_vld;
    logic [W_WIDTH-1:0] weight [N_SRC];

`ifdef LIF_SCHED_CFG_EN
    logic [W_WIDTH-1:0] weight_q [N_SRC];
    logic [W_WIDTH-1:0] weight_d [N_SRC];

    always_comb begin
        weight_d = weight_q;
        if (bus.cfg_we && int'(bus.cfg_addr) < N_SRC)
            weight_d[bus.cfg_addr] = bus.cfg_wdata;
    end

    // NOTE: the weight file is small and must come up with usable synapses, so it is reset like logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SRC; i++)
                weight_q[i] <= W_WIDTH'(def_weight(i));
        end else begin
            weight_q <= weight_d;
        end
    end

    assign weight = weight_q;
`else
    logic cfg_unused;
    assign cfg_unused = ^{bus.cfg_we, bus.cfg_addr, bus.cfg_wdata};

    always_comb begin
        for (int i = 0; i < N_SRC; i++)
            weight[i] = W_WIDTH'(def_weight(i));
    end
`endif

    lif_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .en        (state_q == ACCUM),
        .pending   (pending_q),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .rr_ptr_nxt(rr_ptr_nxt)
    );

    // A spike on the grant edge re-arms the flag; a spike onto an ungranted pending flag is lost.
    assign pending_d     = bus.spike_in | (pending_q & ~grant);
    assign drop_sticky_d = drop_sticky_q | (|(bus.spike_in & pending_q & ~grant));
    assign rr_ptr_d      = rr_ptr_nxt;
    assign acc_sum       = acc_q + ACC_W'(weight[grant_idx]);

    always_comb begin
        state_d         = state_q;
        win_cnt_d       = win_cnt_q;
        acc_d           = acc_q;
        current_out_d   = current_out_q;
        current_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d   = ACCUM;
                    win_cnt_d = '0;
                    acc_d     = '0;
                end
            end
            ACCUM: begin
                win_cnt_d = win_cnt_q + 4'd1;
                if (grant_vld)
                    acc_d = (acc_sum > ACC_MAX) ? ACC_MAX : acc_sum;
                if (win_cnt_q == WIN_LAST)
                    state_d = FLUSH;
            end
            FLUSH: begin
                current_out_d   = W_WIDTH'((acc_q > ACC_MAX) ? ACC_MAX : acc_q);
                current_valid_d = 1'b1;
                acc_d           = '0;
                win_cnt_d       = '0;
                state_d         = (|pending_q) ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            win_cnt_q       <= '0;
            acc_q           <= '0;
            rr_ptr_q        <= '0;
            pending_q       <= '0;
            current_out_q   <= '0;
            current_valid_q <= 1'b0;
            drop_sticky_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            win_cnt_q       <= win_cnt_d;
            acc_q           <= acc_d;
            rr_ptr_q        <= rr_ptr_d;
            pending_q       <= pending_d;
            current_out_q   <= current_out_d;
            current_valid_q <= current_valid_d;
            drop_sticky_q   <= drop_sticky_d;
        end
    end

    assign bus.grant         = grant;
    assign bus.current_out   = current_out_q;
    assign bus.current_valid = current_valid_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.drop_sticky   = drop_sticky_q;

endmodule

// File: tb/tb_lif_spike_scheduler.sv
// Directed bench for lif_spike_scheduler: a vector table of single-window scenarios plus
// hand-written sequences for grant timing, flush overlap, mid-window reset and weight writes.
module tb_lif_spike_scheduler;

    localparam int N_SRC   = 3;
    localparam int W_WIDTH = 4;
    localparam int WINDOW  = 4;
    localparam int VALID_LAT = WINDOW + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lif_sched_if #(.N_SRC(N_SRC), .W_WIDTH(W_WIDTH)) bus ();

    lif_spike_scheduler #(.N_SRC(N_SRC), .W_WIDTH(W_WIDTH), .WINDOW(WINDOW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] s0;
        logic [2:0] s1;
        logic [2:0] s2;
        int         exp_cur;
        logic       exp_drop;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.spike_in  = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Ticks until current_valid is seen, bounded; reports how many edges it took.
    task automatic wait_valid(output logic found, output int edges, output logic [3:0] cur);
        found = 1'b0;
        edges = 0;
        cur   = '0;
        while (!found && edges < 30) begin
            tick();
            edges++;
            if (bus.current_valid) begin
                found = 1'b1;
                cur   = bus.current_out;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic       found;
        int         edges;
        logic [3:0] cur;
        int         vcount;

        vecs[0] = '{3'b001, 3'b000, 3'b000,  5, 1'b0};
        vecs[1] = '{3'b111, 3'b000, 3'b000, 12, 1'b0};
        vecs[2] = '{3'b111, 3'b000, 3'b001, 15, 1'b0};
        vecs[3] = '{3'b010, 3'b010, 3'b000,  4, 1'b1};
        vecs[4] = '{3'b100, 3'b000, 3'b000,  3, 1'b0};
        vecs[5] = '{3'b011, 3'b000, 3'b000,  9, 1'b0};
        vecs[6] = '{3'b110, 3'b000, 3'b000,  7, 1'b0};
        vecs[7] = '{3'b001, 3'b000, 3'b010,  9, 1'b0};
        vecs[8] = '{3'b100, 3'b100, 3'b000,  3, 1'b1};
        vecs[9] = '{3'b001, 3'b001, 3'b000,  5, 1'b1};

        // Reset state.
        do_reset();
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_cur", 32'(bus.current_out), 0);
        check("rst_valid", 32'(bus.current_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_drop", 32'(bus.drop_sticky), 0);

        // Table: spikes on edges 0..2, then one window emits; valid follows edge WINDOW+2.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            bus.spike_in = vecs[v].s0; tick();
            bus.spike_in = vecs[v].s1; tick();
            bus.spike_in = vecs[v].s2; tick();
            bus.spike_in = '0;
            wait_valid(found, edges, cur);
            check($sformatf("v%0d_found", v), 32'(found), 1);
            check($sformatf("v%0d_lat", v), 32'(edges + 2), 32'(VALID_LAT));
            check($sformatf("v%0d_cur", v), 32'(cur), 32'(vecs[v].exp_cur));
            check($sformatf("v%0d_drop", v), 32'(bus.drop_sticky), 32'(vecs[v].exp_drop));
            tick();
            check($sformatf("v%0d_pulse", v), 32'(bus.current_valid), 0);
            check($sformatf("v%0d_idle", v), 32'(bus.busy), 0);
        end

        // Grant timing of a single spike.
        do_reset();
        bus.spike_in = 3'b001; tick();
        bus.spike_in = '0;
        check("t_grant_e0", 32'(bus.grant), 0);
        check("t_busy_e0", 32'(bus.busy), 0);
        tick();
        check("t_busy_e1", 32'(bus.busy), 1);
        check("t_grant_e1", 32'(bus.grant), 32'b001);
        tick();
        check("t_grant_e2", 32'(bus.grant), 0);
        wait_valid(found, edges, cur);
        check("t_cur", 32'(cur), 5);

        // Round-robin order for 111 and pointer back at 0 afterwards.
        do_reset();
        bus.spike_in = 3'b111; tick();
        bus.spike_in = '0;
        tick(); check("rr_g0", 32'(bus.grant), 32'b001);
        tick(); check("rr_g1", 32'(bus.grant), 32'b010);
        tick(); check("rr_g2", 32'(bus.grant), 32'b100);
        wait_valid(found, edges, cur);
        check("rr_cur", 32'(cur), 12);
        tick();
        bus.spike_in = 3'b011; tick();
        bus.spike_in = '0;
        tick(); check("rr_ptr0", 32'(bus.grant), 32'b001);
        wait_valid(found, edges, cur);
        check("rr_cur2", 32'(cur), 9);

        // Spike landing on the FLUSH entry edge is carried into the next window.
        do_reset();
        bus.spike_in = 3'b001; tick();
        bus.spike_in = '0;
        repeat (4) tick();
        bus.spike_in = 3'b100; tick();
        bus.spike_in = '0;
        check("fl_busy", 32'(bus.busy), 1);
        check("fl_grant", 32'(bus.grant), 0);
        tick();
        check("fl_valid", 32'(bus.current_valid), 1);
        check("fl_cur", 32'(bus.current_out), 5);
        check("fl_busy2", 32'(bus.busy), 1);
        check("fl_grant2", 32'(bus.grant), 32'b100);
        wait_valid(found, edges, cur);
        check("fl_cur2", 32'(cur), 3);
        tick();

        // Reset mid-window with acc=9 and a drop recorded.
        bus.spike_in = 3'b011; tick();
        bus.spike_in = 3'b001; tick();
        bus.spike_in = '0;
        tick();
        tick();
        check("mr_drop_pre", 32'(bus.drop_sticky), 1);
        check("mr_busy_pre", 32'(bus.busy), 1);
        #2 reset = 1'b0;
        #1;
        check("mr_cur", 32'(bus.current_out), 0);
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_grant", 32'(bus.grant), 0);
        check("mr_valid", 32'(bus.current_valid), 0);
        check("mr_drop", 32'(bus.drop_sticky), 0);
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.current_valid) vcount++;
        end
        check("mr_no_pulse", 32'(vcount), 0);
        check("mr_idle", 32'(bus.busy), 0);

        // Weight writes: effective only with the configuration build, old weight on the same edge.
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 4'd9; tick();
        bus.cfg_we = 1'b0;
        bus.spike_in = 3'b001; tick();
        bus.spike_in = '0;
        wait_valid(found, edges, cur);
`ifdef LIF_SCHED_CFG_EN
        check("cfg_w0", 32'(cur), 9);
`else
        check("cfg_w0", 32'(cur), 5);
`endif
        tick();
        bus.spike_in = 3'b010; tick();
        bus.spike_in = '0;
        tick();
        check("cfg_grant1", 32'(bus.grant), 32'b010);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 4'd2; tick();
        bus.cfg_we = 1'b0;
        wait_valid(found, edges, cur);
        check("cfg_old_w", 32'(cur), 4);
        tick();
        bus.spike_in = 3'b010; tick();
        bus.spike_in = '0;
        wait_valid(found, edges, cur);
`ifdef LIF_SCHED_CFG_EN
        check("cfg_new_w", 32'(cur), 2);
`else
        check("cfg_new_w", 32'(cur), 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
